// File: rtl/param_op_fifo_pkg.sv
// param_op_fifo shared definitions.
// Operation mode encodings sampled with each write.
package param_op_fifo_pkg;

    localparam logic [1:0] MODE_MUL  = 2'b00;
    localparam logic [1:0] MODE_ADD  = 2'b01;
    localparam logic [1:0] MODE_PASS = 2'b10;
    localparam logic [1:0] MODE_MAC  = 2'b11;

endpackage

// File: rtl/op_fifo_ram.sv
// Simple dual-port result storage for param_op_fifo.
// Synchronous write, registered read; maps onto block RAM.
module op_fifo_ram #(
    parameter int AW = 4,
    parameter int WW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [WW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [WW-1:0] rdata_o
);

    logic [WW-1:0] mem_q [2**AW];
    logic [WW-1:0] rdata_q;

    // Write port: store one result per accepted write.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: output register holds the last word read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/param_op_fifo.sv
// FIFO that transforms each operand pair on write.
// Modes: multiply, add, pass-through, multiply-accumulate.
module param_op_fifo
    import param_op_fifo_pkg::*;
#(
    parameter int DW         = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int AF_MARGIN  = 2,
    parameter int AE_MARGIN  = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WR,
    input  logic [1:0]            MODE,
    input  logic                  ACC_CLR,
    input  logic [2*DW-1:0]       DIN,
    input  logic                  RD,
    output logic [2*DW-1:0]       DOUT,
    output logic                  VALID,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic                  AFULL,
    output logic                  AEMPTY,
    output logic [DEPTH_LOG2:0]   COUNT,
    output logic                  OVF,
    output logic                  UDF
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int RW    = 2 * DW;
    localparam int CW    = DEPTH_LOG2 + 1;

    localparam logic [CW-1:0] FULL_TH = CW'(DEPTH);
    localparam logic [CW-1:0] AF_TH   = CW'(DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] AE_TH   = CW'(AE_MARGIN);

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [RW-1:0]         acc_q, acc_d;
    logic                  empty_q, full_q;
    logic                  afull_q, aempty_q;
    logic                  valid_q, ovf_q, udf_q;

    logic          wr_acc, rd_acc;
    logic [DW-1:0] op_a, op_b;
    logic [RW-1:0] prod, sum, acc_base, mac_val;
    logic [RW-1:0] result;

    assign wr_acc = WR && !full_q;
    assign rd_acc = RD && !empty_q;

    assign op_a     = DIN[RW-1:DW];
    assign op_b     = DIN[DW-1:0];
    assign prod     = RW'(op_a) * RW'(op_b);
    assign sum      = RW'(op_a) + RW'(op_b);
    assign acc_base = ACC_CLR ? '0 : acc_q;
    assign mac_val  = acc_base + prod;

    // Select the value stored for this write.
    always_comb begin
        result = prod;
        unique case (MODE)
            MODE_MUL:  result = prod;
            MODE_ADD:  result = sum;
            MODE_PASS: result = DIN;
            MODE_MAC:  result = mac_val;
        endcase
    end

    // Next pointers, occupancy and accumulator.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        acc_d    = acc_base;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (MODE == MODE_MAC) begin
                acc_d = mac_val;
            end
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end
    end

    // State and flag registers; flags derive from the new count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            acc_q    <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == FULL_TH);
            afull_q  <= (count_d >= AF_TH);
            aempty_q <= (count_d <= AE_TH);
            valid_q  <= rd_acc;
            ovf_q    <= WR && full_q;
            udf_q    <= RD && empty_q;
        end
    end

    op_fifo_ram #(
        .AW (DEPTH_LOG2),
        .WW (RW)
    ) u_ram (
        .clk_i   (CLK),
        .rst_i   (RST),
        .we_i    (wr_acc && !RST),
        .waddr_i (wr_ptr_q),
        .wdata_i (result),
        .re_i    (rd_acc && !RST),
        .raddr_i (rd_ptr_q),
        .rdata_o (DOUT)
    );

    assign VALID  = valid_q;
    assign EMPTY  = empty_q;
    assign FULL   = full_q;
    assign AFULL  = afull_q;
    assign AEMPTY = aempty_q;
    assign COUNT  = count_q;
    assign OVF    = ovf_q;
    assign UDF    = udf_q;

endmodule

// File: doc/param_op_fifo.md
Name: param_op_fifo

Overview:
- Parametrised successor to the team's 16x16 multiply-on-write FIFO.
- Each written word DIN = {A, B} (two DW-bit operands) is transformed by a per-write operation and stored as a 2*DW-bit result in a 2**DEPTH_LOG2-entry FIFO.
- Adds selectable operation mode (multiply, add, pass-through, multiply-accumulate), occupancy count, programmable almost-full/almost-empty flags and overflow/underflow pulses.
- Sits between a producer issuing operand pairs and a consumer draining results.

Parameters:
- DW, 8, operand width; DIN is 2*DW bits, DOUT is 2*DW bits.
- DEPTH_LOG2, 4, log2 of entry count (DEPTH = 16 by default).
- AF_MARGIN, 2, AFULL asserted when COUNT >= DEPTH - AF_MARGIN.
- AE_MARGIN, 2, AEMPTY asserted when COUNT <= AE_MARGIN.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- WR  in  1  write request.
- MODE  in  2  operation, sampled with WR: 00 MUL, 01 ADD, 10 PASS, 11 MAC.
- ACC_CLR  in  1  clears MAC accumulator.
- DIN  in  2*DW  {A = DIN[2DW-1:DW], B = DIN[DW-1:0]}.
- RD  in  1  read request.
- DOUT  out  2*DW  read data, registered.
- VALID  out  1  one-cycle strobe, DOUT valid.
- EMPTY  out  1  no entries.
- FULL  out  1  DEPTH entries.
- AFULL  out  1  almost full.
- AEMPTY  out  1  almost empty.
- COUNT  out  DEPTH_LOG2+1  occupancy.
- OVF  out  1  one-cycle pulse, write rejected.
- UDF  out  1  one-cycle pulse, read rejected.

Behaviour:
- Reset values, applied on a clock edge with RST=1: DOUT=0, VALID=0, EMPTY=1, FULL=0, AFULL=0, AEMPTY=1, COUNT=0, OVF=0, UDF=0, pointers=0, accumulator=0.
- Reset mid-operation discards all contents. RST has priority over every other input.
- Write accept: WR=1 and FULL=0. The result is stored at the write pointer in the same edge, and the pointer increments mod DEPTH.
- Write reject: WR=1 with FULL=1 is ignored, even if RD=1 in the same cycle. OVF=1 in the next cycle.
- Operations, all results 2*DW bits:
  - MUL: A*B, unsigned.
  - ADD: A+B, zero-extended.
  - PASS: {A,B} unchanged.
  - MAC: acc_next = acc + A*B, mod 2**(2DW). The stored value is acc_next and the accumulator updates to acc_next.
- Accumulator updates only on an accepted MAC write.
- ACC_CLR=1 zeroes the accumulator. If ACC_CLR=1 and an accepted MAC write occur together, stored = A*B and acc = A*B.
- Read accept: RD=1 and EMPTY=0. DOUT is loaded from the read pointer and VALID=1 in the next cycle (latency 1). The read pointer increments mod DEPTH.
- Read reject: RD=1 with EMPTY=1 is ignored, even with a simultaneous WR (no fall-through). UDF=1 in the next cycle.
- VALID=0 on every cycle without an accepted read. DOUT holds its last value.
- Simultaneous accepted WR and RD leave COUNT unchanged.
- COUNT, EMPTY, FULL, AFULL and AEMPTY are registered and all updated on the same edge:
  - EMPTY = (COUNT==0), FULL = (COUNT==DEPTH).
  - AFULL and AEMPTY use the margins above.
- Pointers are DEPTH_LOG2 bits and wrap naturally. There is no separate wrap state; occupancy comes from COUNT.

Decomposition:
- Package param_op_fifo_pkg holds the mode localparams MODE_MUL, MODE_ADD, MODE_PASS and MODE_MAC.
- One sub-module, op_fifo_ram: simple dual-port RAM, DEPTH x 2*DW, synchronous write, registered read. It is inferable as block RAM.
- The operation datapath, accumulator, pointers, count and flags live in the top level.

Test Plan:
- Reset then idle -> EMPTY=1, AEMPTY=1, COUNT=0, VALID=0, DOUT=0.
- MUL: write 16'h0304, then read -> one cycle after RD, VALID=1 and DOUT=16'h000C. Also check 16'hFFFF -> 16'hFE01.
- Modes: ADD 16'hFF01 -> 16'h0100. PASS 16'hABCD -> 16'hABCD.
- MAC sequence 16'h0202, 16'h0303, then ACC_CLR with 16'h0101 -> reads 16'h0004, 16'h000D, 16'h0001.
- Fill 16 entries, then WR with RD=1 -> write rejected, OVF pulses. COUNT: 16 -> 15 (the read is accepted). AFULL is set from COUNT=14.
- Underflow and wrap:
  - RD while empty -> UDF pulse, VALID=0.
  - Then 40 random WR/RD cycles -> all reads match the model in order, pointers wrap and COUNT matches the model every cycle.
- Reset asserted with COUNT=5 -> next cycle COUNT=0 and EMPTY=1. A subsequent read returns only post-reset data.
